instr_encoder: RTL and testbench

Program loader that encodes RV32I instruction fields into 32-bit words and writes them sequentially into instruction memory. Covers the four instruction classes the single-cycle core decodes: R-type, load, store and branch. Field tuples arrive on a valid/ready handshake from the testbench or boot sequencer. Encoded words leave on a registered memory write port at auto-incrementing word addresses, so the core can later fetch and decode them.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/instr_word_encoder.sv | 46 ++++
 rtl/instr_encoder.sv | 115 +++++++++++
 tb/tb_instr_encoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, instruction classes, loader bundles.
// Opcode constants are shared with the core's opcode decoder.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    typedef enum logic [1:0] {
        CLS_R      = 2'b00,
        CLS_LOAD   = 2'b01,
        CLS_STORE  = 2'b10,
        CLS_BRANCH = 2'b11
    } instr_class_e;

    typedef struct packed {
        instr_class_e cls;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [2:0]   funct3;
        logic         funct7b5;
        logic [12:0]  imm;
    } instr_fields_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } load_state_e;

    // 13-bit immediate fits the signed 12-bit I/S field.
    function automatic logic imm_fits12(input logic [12:0] imm);
        return imm[12] == imm[11];
    endfunction

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational RV32I encoder: field bundle -> 32-bit word + range flag.
// Ports: fields_i (class/regs/funct/imm), word_o, range_err_o.
module instr_word_encoder
    import riscv_pkg::*;
(
    input  instr_fields_t fields_i,
    output logic [31:0]   word_o,
    output logic          range_err_o
);

    logic [12:0] imm;
    assign imm = fields_i.imm;

    always_comb begin
        word_o      = '0;
        range_err_o = 1'b0;
        unique case (fields_i.cls)
            CLS_R: begin
                word_o = {fields_i.funct7b5 ? FUNCT7_ALT : 7'b0,
                          fields_i.rs2, fields_i.rs1,
                          fields_i.funct3, fields_i.rd, OP_RTYPE};
            end
            CLS_LOAD: begin
                word_o = {imm[11:0], fields_i.rs1,
                          fields_i.funct3, fields_i.rd, OP_LOAD};
                range_err_o = !imm_fits12(imm);
            end
            CLS_STORE: begin
                word_o = {imm[11:5], fields_i.rs2, fields_i.rs1,
                          fields_i.funct3, imm[4:0], OP_STORE};
                range_err_o = !imm_fits12(imm);
            end
            CLS_BRANCH: begin
                // B-type scatters the byte offset; bit 0 is implicit.
                word_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1,
                          fields_i.funct3, imm[4:1], imm[11], OP_BRANCH};
                range_err_o = imm[0];
            end
            default: begin
                word_o      = '0;
                range_err_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes RV32I field tuples and writes them to imem
// at auto-incrementing word addresses through one registered stage.
// Ports: clk, rst (sync, active-high), clr, in_valid/in_ready handshake,
// in_class/rd/rs1/rs2/funct3/funct7b5/imm fields, imem_we/addr/wdata,
// count, full, err.
// Macro INSTR_ENCODER_CHECK_EN enables immediate range checking.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_class,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [2:0]    funct3,
    input  logic          funct7b5,
    input  logic [12:0]   imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err
);

    localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    load_state_e   state_q;
    logic [AW:0]   count_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          err_q;

    instr_fields_t fields;
    logic [31:0]   word;
    logic          viol;
    logic          fire;
    logic          rej;
    logic          wr_en;

    always_comb begin
        fields          = '0;
        fields.cls      = instr_class_e'(in_class);
        fields.rd       = rd;
        fields.rs1      = rs1;
        fields.rs2      = rs2;
        fields.funct3   = funct3;
        fields.funct7b5 = funct7b5;
        fields.imm      = imm;
    end

    instr_word_encoder u_enc (
        .fields_i    (fields),
        .word_o      (word),
        .range_err_o (viol)
    );

    assign in_ready = !rst && !clr && (state_q == ST_LOAD);
    assign fire     = in_valid && in_ready;

`ifdef INSTR_ENCODER_CHECK_EN
    // Rejected tuples still complete the handshake but never write.
    assign rej = fire && viol;
`else
    logic unused_viol;
    assign unused_viol = viol;
    assign rej         = 1'b0;
`endif

    assign wr_en = fire && !rej;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q  <= wr_en;
            err_q <= rej;
            if (wr_en) begin
                addr_q  <= count_q[AW-1:0];
                wdata_q <= word;
            end
            // clr never coincides with wr_en since in_ready is low.
            if (clr) begin
                state_q <= ST_LOAD;
                count_q <= '0;
            end else if (wr_en) begin
                count_q <= count_q + ONE;
                if (count_q == LAST) begin
                    state_q <= ST_FULL;
                end
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (state_q == ST_FULL);
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed test-plan vectors plus
// randomized tuples, clr and rst against a field-arithmetic model.
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_class = '0;
    logic [4:0]    rd = '0;
    logic [4:0]    rs1 = '0;
    logic [4:0]    rs2 = '0;
    logic [2:0]    funct3 = '0;
    logic          funct7b5 = 1'b0;
    logic [12:0]   imm = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    always #5 clk = ~clk;

    instr_encoder #(.AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .imm        (imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   word;
        bit            err;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    int            m_count = 0;
    bit            m_full  = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [31:0]   m_wdata = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Builds the word from field positions with shifts and masks.
    function automatic logic [31:0] ref_enc(input int cls, input int rdv,
        input int r1, input int r2, input int f3, input int f7, input int iv);
        int w;
        w = 0;
        case (cls)
            0: w = ((f7 != 0 ? 32 : 0) << 25) | (r2 << 20) | (r1 << 15)
                   | (f3 << 12) | (rdv << 7) | 'h33;
            1: w = ((iv & 'hFFF) << 20) | (r1 << 15) | (f3 << 12)
                   | (rdv << 7) | 'h03;
            2: w = (((iv >> 5) & 'h7F) << 25) | (r2 << 20) | (r1 << 15)
                   | (f3 << 12) | ((iv & 'h1F) << 7) | 'h23;
            default: w = (((iv >> 12) & 1) << 31)
                   | (((iv >> 5) & 'h3F) << 25) | (r2 << 20) | (r1 << 15)
                   | (f3 << 12) | (((iv >> 1) & 'hF) << 8)
                   | (((iv >> 11) & 1) << 7) | 'h63;
        endcase
        return w;
    endfunction

    function automatic bit ref_bad(input int cls, input int iv);
`ifdef INSTR_ENCODER_CHECK_EN
        if (cls == 1 || cls == 2) return (iv > 2047) || (iv < -2048);
        if (cls == 3) return (iv % 2) != 0;
        return 1'b0;
`else
        return (cls < 0) && (iv < 0);
`endif
    endfunction

    task automatic step(input bit v, input int cls, input int rdv,
        input int r1, input int r2, input int f3, input int f7,
        input int iv, input bit c, input bit r, input bit use_exp,
        input logic [31:0] exp_word, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_class = cls[1:0];
        rd       = rdv[4:0];
        rs1      = r1[4:0];
        rs2      = r2[4:0];
        funct3   = f3[2:0];
        funct7b5 = f7[0];
        imm      = iv[12:0];
        clr      = c;
        rst      = r;
        #1;
        check("in_ready", in_ready, !r && !c && !m_full);
        acc = v && !r && !c && !m_full;
        if (acc) begin
            e.addr = m_count[AW-1:0];
            e.word = use_exp ? exp_word
                             : ref_enc(cls, rdv, r1, r2, f3, f7, iv);
            e.err  = ref_bad(cls, iv);
            q.push_back(e);
            if (!e.err) begin
                m_count++;
                if (m_count == DEPTH) m_full = 1'b1;
            end
        end
        if (r || c) begin
            m_count = 0;
            m_full  = 1'b0;
        end
    endtask

    task automatic idle(input bit c, input bit r);
        bit acc;
        step(1'b0, 0, 0, 0, 0, 0, 0, 0, c, r, 1'b0, 32'h0, acc);
    endtask

    task automatic send(input int cls, input int rdv, input int r1,
        input int r2, input int f3, input int f7, input int iv,
        input bit use_exp, input logic [31:0] exp_word);
        bit acc;
        int n;
        n = 0;
        do begin
            step(1'b1, cls, rdv, r1, r2, f3, f7, iv, 1'b0, 1'b0,
                 use_exp, exp_word, acc);
            n++;
        end while (!acc && n < 20);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
    endtask

    // Monitor: one registered stage after each step's transfer edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                m_addr  = '0;
                m_wdata = '0;
                check("rst_we", imem_we, 0);
                check("rst_err", err, 0);
                check("rst_addr", imem_addr, 0);
                check("rst_wdata", imem_wdata, 0);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (e.err) begin
                    check("err_pulse", err, 1);
                    check("err_we", imem_we, 0);
                    check("err_hold_addr", imem_addr, m_addr);
                end else begin
                    check("we", imem_we, 1);
                    check("addr", imem_addr, e.addr);
                    check("wdata", imem_wdata, e.word);
                    check("err_low", err, 0);
                    m_addr  = e.addr;
                    m_wdata = e.word;
                end
            end else begin
                check("idle_we", imem_we, 0);
                check("idle_err", err, 0);
                check("hold_addr", imem_addr, m_addr);
                check("hold_wdata", imem_wdata, m_wdata);
            end
            check("count", count, m_count);
            check("full", full, m_full);
        end
    end

    initial begin
        bit acc;
        logic [31:0] w2048;
        repeat (3) idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);

        send(0, 3, 1, 2, 0, 0, 0, 1'b1, 32'h002081B3);
        idle(1'b1, 1'b0);
        send(0, 1, 2, 3, 0, 1, 0, 1'b1, 32'h403100B3);
        idle(1'b1, 1'b0);

        send(1, 5, 0, 0, 2, 0, 8, 1'b1, 32'h00802283);
        send(2, 0, 2, 6, 2, 0, 4, 1'b1, 32'h00612223);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);

        send(3, 0, 1, 2, 0, 0, -4, 1'b1, 32'hFE208EE3);
        idle(1'b1, 1'b0);

        // Fill all DEPTH words, hold the fifth, release it with clr.
        for (int i = 0; i < DEPTH; i++) send(0, i + 1, 1, 2, 0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 0, 9, 4, 5, 7, 1, 0, 1'b0, 1'b0, 1'b0, 0, acc);
            check("held_tuple", acc, 0);
        end
        step(1'b1, 0, 9, 4, 5, 7, 1, 0, 1'b1, 1'b0, 1'b0, 0, acc);
        send(0, 9, 4, 5, 7, 1, 0, 1'b0, 0);
        idle(1'b1, 1'b0);

        // Out-of-range immediates: err under checking, truncated otherwise.
        w2048 = 32'h80002083;
        send(1, 1, 0, 0, 2, 0, 2048, 1'b1, w2048);
        send(3, 0, 1, 2, 0, 0, 3, 1'b0, 0);
        idle(1'b0, 1'b0);

        // rst mid-stream squashes the following write.
        send(2, 0, 3, 4, 1, 0, -100, 1'b0, 0);
        step(1'b1, 0, 1, 1, 1, 0, 0, 0, 1'b0, 1'b1, 1'b0, 0, acc);
        idle(1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            int u;
            int cls;
            u   = int'($urandom_range(0, 8191));
            cls = int'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, cls,
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)),
                 (u >= 4096) ? u - 8192 : u,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0,
                 1'b0, 0, acc);
        end

        repeat (3) idle(1'b0, 1'b0);
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
